// File: rtl/sort_out_packer.sv
// Packs sparse sorter lanes into a first-word-fall-through FIFO and sequences batch drain/done.
// Optional pop counter output out_cnt_o is enabled by defining SORT_OUTPACK_CNT_EN.
module sort_out_packer #(
    parameter int SORT_FUC_MAX_NUM      = 256,
    parameter int SORT_PERF_OUTPORT_NUM = 4,
    parameter int OUTPACK_FIFO_DEPTH    = 16,
    localparam int DW = $clog2(SORT_FUC_MAX_NUM),
    localparam int N  = SORT_PERF_OUTPORT_NUM
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_vld_i,
    input  logic [N*DW-1:0] in_data_i,
    input  logic            in_done_vld_i,
    output logic            out_vld_o,
    input  logic            out_rdy_i,
    output logic [DW-1:0]   out_data_o,
    output logic            out_last_o,
    output logic            out_done_o,
`ifdef SORT_OUTPACK_CNT_EN
    output logic [DW:0]     out_cnt_o,
`endif
    output logic            ovf_o
);

    // state    | meaning
    // ST_IDLE  | accepting beats, waiting for end-of-batch
    // ST_DRAIN | batch closed, emptying FIFO, inputs rejected
    // ST_DONE  | one-cycle out_done_o pulse, inputs rejected
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int PW = $clog2(OUTPACK_FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(OUTPACK_FIFO_DEPTH);
    localparam logic [PW:0] ONE_C   = (PW+1)'(1);

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [DW-1:0] mem_q [OUTPACK_FIFO_DEPTH];

    logic [PW-1:0] lane_addr [N];
    logic [PW:0]   push_num;
    logic [PW:0]   free_slots;
    logic          in_busy;
    logic          any_in;
    logic          fits;
    logic          push_en;
    logic          pop_en;

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        push_num = '0;
        for (int k = 0; k < N; k++) begin
            lane_addr[k] = wr_ptr_q + push_num[PW-1:0];
            if (in_vld_i[k]) begin
                push_num = push_num + ONE_C;
            end
        end
    end

    always_comb begin
        free_slots = DEPTH_C - count_q;
        in_busy    = (state_q != ST_IDLE);
        any_in     = |in_vld_i;
        fits       = (push_num <= free_slots);
        push_en    = !in_busy && any_in && fits;
        pop_en     = out_vld_o && out_rdy_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + push_num[PW-1:0];
            count_d  = count_d + push_num;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_d - ONE_C;
        end
        if (in_busy && (any_in || in_done_vld_i)) begin
            ovf_d = 1'b1;
        end
        if (!in_busy && any_in && !fits) begin
            ovf_d = 1'b1;
        end
    end

    // An empty-FIFO done skips DRAIN so out_done_o follows on the very next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_done_vld_i) begin
                    state_d = (count_d == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int k = 0; k < N; k++) begin
                if (in_vld_i[k]) begin
                    mem_q[lane_addr[k]] <= in_data_i[k*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        out_vld_o  = (count_q != '0);
        out_data_o = out_vld_o ? mem_q[rd_ptr_q] : '0;
        out_last_o = (state_q == ST_DRAIN) && out_vld_o && (count_q == ONE_C);
        out_done_o = (state_q == ST_DONE);
        ovf_o      = ovf_q;
    end

`ifdef SORT_OUTPACK_CNT_EN
    logic [DW:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_DONE) begin
            cnt_d = '0;
        end else if (pop_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_sort_out_packer.sv
// Self-checking bench for sort_out_packer against a queue-based reference model.
// Covers out_cnt_o as well when built with SORT_OUTPACK_CNT_EN.
module tb_sort_out_packer;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  in_vld_i = '0;
    logic [31:0]   in_data_i = '0;
    logic          in_done_vld_i = 1'b0;
    logic          out_vld_o;
    logic          out_rdy_i = 1'b0;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic          out_done_o;
    logic          ovf_o;
`ifdef SORT_OUTPACK_CNT_EN
    logic [DW:0]   out_cnt_o;
`endif

    sort_out_packer #(
        .SORT_FUC_MAX_NUM     (256),
        .SORT_PERF_OUTPORT_NUM(N),
        .OUTPACK_FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_vld_i     (in_vld_i),
        .in_data_i    (in_data_i),
        .in_done_vld_i(in_done_vld_i),
        .out_vld_o    (out_vld_o),
        .out_rdy_i    (out_rdy_i),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .out_done_o   (out_done_o),
`ifdef SORT_OUTPACK_CNT_EN
        .out_cnt_o    (out_cnt_o),
`endif
        .ovf_o        (ovf_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: element queue plus batch phase flags
    logic [DW-1:0] m_q[$];
    bit            m_drain;
    bit            m_done;
    bit            m_ovf;
    int            m_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_drain = 1'b0;
        m_done  = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_data;
        exp_data = (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0;
        check_val({tag, ".vld"},  32'(out_vld_o),  32'(m_q.size() != 0));
        check_val({tag, ".data"}, 32'(out_data_o), exp_data);
        check_val({tag, ".last"}, 32'(out_last_o), 32'(m_drain && (m_q.size() == 1)));
        check_val({tag, ".done"}, 32'(out_done_o), 32'(m_done));
        check_val({tag, ".ovf"},  32'(ovf_o),      32'(m_ovf));
`ifdef SORT_OUTPACK_CNT_EN
        check_val({tag, ".cnt"},  32'(out_cnt_o),  32'(m_cnt & 9'h1ff));
`endif
    endtask

    // Called just after a falling edge: drive one beat, advance the model across the
    // next rising edge, then check at the following falling edge.
    task automatic step(input string tag, input logic [N-1:0] vld, input logic [31:0] data,
                        input logic done, input logic rdy);
        int  pc;
        int  free;
        bit  pop;
        bit  busy;
        in_vld_i      = vld;
        in_data_i     = data;
        in_done_vld_i = done;
        out_rdy_i     = rdy;

        free = DEPTH - m_q.size();
        pop  = (m_q.size() != 0) && rdy;
        busy = m_drain || m_done;
        pc   = $countones(vld);
        if (pop) void'(m_q.pop_front());
        if (busy) begin
            if (vld != 0 || done) m_ovf = 1'b1;
        end else if (pc > 0) begin
            if (pc <= free) begin
                for (int k = 0; k < N; k++)
                    if (vld[k]) m_q.push_back(data[k*DW +: DW]);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (m_done) begin
            m_done = 1'b0;
            m_cnt  = 0;
        end else begin
            if (pop) m_cnt++;
            if (m_drain) begin
                if (m_q.size() == 0) begin
                    m_drain = 1'b0;
                    m_done  = 1'b1;
                end
            end else if (done) begin
                if (m_q.size() == 0) m_done = 1'b1;
                else m_drain = 1'b1;
            end
        end

        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        in_vld_i      = '0;
        in_done_vld_i = 1'b0;
        out_rdy_i     = 1'b0;
        rst           = 1'b0;
        #1;
        check_val({tag, ".rst_vld"},  32'(out_vld_o),  32'd0);
        check_val({tag, ".rst_data"}, 32'(out_data_o), 32'd0);
        check_val({tag, ".rst_last"}, 32'(out_last_o), 32'd0);
        check_val({tag, ".rst_done"}, 32'(out_done_o), 32'd0);
        check_val({tag, ".rst_ovf"},  32'(ovf_o),      32'd0);
`ifdef SORT_OUTPACK_CNT_EN
        check_val({tag, ".rst_cnt"},  32'(out_cnt_o),  32'd0);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] vld;
        bit           busy;
        bit           dn;
        model_reset();
        @(negedge clk);
        do_reset("init");

        // two sparse lanes, delivered in lane order on consecutive cycles
        step("sparse", 4'b1010, {8'd9, 8'd0, 8'd5, 8'd0}, 1'b0, 1'b1);
        check_val("sparse.first", 32'(out_data_o), 32'd5);
        step("sparse", 4'b0000, 32'd0, 1'b0, 1'b1);
        check_val("sparse.second", 32'(out_data_o), 32'd9);
        step("sparse", 4'b0000, 32'd0, 1'b0, 1'b1);

        // full beat together with done: last on the 4th element, then done pulse
        step("batch4", 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step("batch4", 4'b0000, 32'd0, 1'b0, 1'b1);

        // done on an empty FIFO
        step("empty_done", 4'b0000, 32'd0, 1'b1, 1'b1);
        check_val("empty_done.pulse", 32'(out_done_o), 32'd1);
        for (int i = 0; i < 3; i++) step("empty_done", 4'b0000, 32'd0, 1'b0, 1'b1);

        // 20 elements, ready toggling, pointers wrap past depth 16
        do_reset("stream");
        for (int b = 0; b < 5; b++) begin
            step("stream", 4'b1111, $urandom, (b == 4), (b % 2) == 0);
            for (int i = 0; i < 3; i++) step("stream", 4'b0000, 32'd0, 1'b0, (i % 2) == 1);
        end
        for (int i = 0; i < 40 && !m_done; i++) step("stream", 4'b0000, 32'd0, 1'b0, (i % 2) == 0);
        check_val("stream.done_seen", 32'(out_done_o), 32'd1);
`ifdef SORT_OUTPACK_CNT_EN
        check_val("stream.cnt20", 32'(out_cnt_o), 32'd20);
`endif
        step("stream", 4'b0000, 32'd0, 1'b0, 1'b1);

        // fill 14, then a 3-lane beat must be dropped whole
        do_reset("ovf");
        for (int b = 0; b < 3; b++) step("ovf", 4'b1111, $urandom, 1'b0, 1'b0);
        step("ovf", 4'b0011, $urandom, 1'b0, 1'b0);
        step("ovf", 4'b0111, $urandom, 1'b0, 1'b0);
        check_val("ovf.flag", 32'(ovf_o), 32'd1);
        for (int i = 0; i < 16; i++) step("ovf_drain", 4'b0000, 32'd0, 1'b0, 1'b1);
        check_val("ovf.sticky", 32'(ovf_o), 32'd1);

        // asynchronous reset with six elements pending in DRAIN
        do_reset("midrst");
        step("midrst", 4'b1111, $urandom, 1'b0, 1'b0);
        step("midrst", 4'b0011, $urandom, 1'b0, 1'b0);
        step("midrst", 4'b0000, 32'd0, 1'b1, 1'b0);
        step("midrst", 4'b0000, 32'd0, 1'b0, 1'b0);
        step("midrst", 4'b0001, $urandom, 1'b0, 1'b0);
        #2;
        do_reset("midrst");
        for (int i = 0; i < 5; i++) step("midrst_after", 4'b0000, 32'd0, 1'b0, 1'b1);

        // random legal traffic with batches
        do_reset("rand");
        for (int i = 0; i < 1500; i++) begin
            busy = m_drain || m_done;
            vld  = (busy || $urandom_range(0, 2) != 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            dn   = !busy && ($urandom_range(0, 19) == 0);
            step("rand", vld, $urandom, dn, $urandom_range(0, 7) != 0);
        end

        // random traffic including protocol violations and overflows
        do_reset("rand_err");
        for (int i = 0; i < 500; i++) begin
            vld = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            dn  = ($urandom_range(0, 15) == 0);
            step("rand_err", vld, $urandom, dn, $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_out_packer.md
SORT_OUT_PACKER -- requirements
Module: sort_out_packer

Interface
REQ-001 SHALL have parameter SORT_FUC_MAX_NUM, default 256, meaning the key range; data width DW = $clog2(SORT_FUC_MAX_NUM).
REQ-002 SHALL have parameter SORT_PERF_OUTPORT_NUM, default 4, meaning the number of parallel lanes from the sorter output stage (N).
REQ-003 SHALL have parameter OUTPACK_FIFO_DEPTH, default 16, meaning the FIFO entries; it is a power of two and at least 2*N.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 SHALL have port in_vld_i, input, N bits: per-lane valid from the sorter.
REQ-007 SHALL have port in_data_i, input, N*DW bits: lane k occupies bits [k*DW +: DW].
REQ-008 SHALL have port in_done_vld_i, input, 1 bit: one-cycle end-of-batch pulse from the sorter.
REQ-009 SHALL have port out_vld_o, output, 1 bit: the head element is valid.
REQ-010 SHALL have port out_rdy_i, input, 1 bit: the consumer accepts the head element.
REQ-011 SHALL have port out_data_o, output, DW bits: the head element.
REQ-012 SHALL have port out_last_o, output, 1 bit: the head element is the final element of the batch.
REQ-013 SHALL have port out_done_o, output, 1 bit: one-cycle pulse when the batch is fully drained.
REQ-014 SHALL have port ovf_o, output, 1 bit: sticky overflow or protocol error flag.

Function
REQ-015 Compaction: on each clock edge, the lanes set in in_vld_i SHALL be written to consecutive FIFO slots in ascending lane order, lane 0 first; sparse masks are legal.
REQ-016 Write acceptance: the beat SHALL be written only if popcount(in_vld_i) <= free slots, where free slots are counted before the edge and a concurrent pop is not credited.
REQ-017 Otherwise the entire beat SHALL be dropped and ovf_o set; a partial write is never made.
REQ-018 The FIFO SHALL be first-word fall-through: an element written at edge k is visible on out_vld_o/out_data_o from edge k when the FIFO was empty.
REQ-019 out_vld_o SHALL equal "FIFO not empty"; a pop occurs when out_vld_o && out_rdy_i.
REQ-020 out_data_o SHALL be held stable while out_vld_o=1 and out_rdy_i=0.
REQ-021 Pointers SHALL be log2(OUTPACK_FIFO_DEPTH) bits, wrapping modulo depth; occupancy SHALL be log2(depth)+1 bits; a simultaneous push and pop SHALL update occupancy by pushed-1.
REQ-022 The FSM SHALL have three states: IDLE, DRAIN, DONE.
REQ-023 IDLE -> DRAIN on in_done_vld_i; beats present in that same cycle are written and belong to the batch.
REQ-024 DRAIN -> DONE on the edge where occupancy becomes 0, or immediately if it is already 0.
REQ-025 DONE -> IDLE after one cycle; out_done_o SHALL be 1 only in DONE.
REQ-026 out_last_o SHALL be 1 when state==DRAIN, out_vld_o=1 and occupancy==1.
REQ-027 A done with an empty FIFO SHALL give out_done_o on the next cycle and never assert out_last_o.
REQ-028 In DRAIN or DONE, any in_vld_i bit or in_done_vld_i SHALL be dropped and SHALL set ovf_o.
REQ-029 ovf_o SHALL clear only on reset.

Reset
REQ-030 While rst=0: pointers and occupancy = 0, FSM = IDLE, ovf_o = 0, and out_vld_o, out_last_o and out_done_o = 0.
REQ-031 out_data_o SHALL be 0 during reset; FIFO storage itself SHALL not be reset.
REQ-032 Reset asserted mid-batch SHALL discard all contents and the pending done, with no out_done_o.
REQ-033 The first accepted input SHALL be the first edge after rst rises.

Configuration
REQ-034 With SORT_OUTPACK_CNT_EN defined, an extra output port out_cnt_o (DW+1 bits) SHALL count pops since the last out_done_o.
REQ-035 out_cnt_o SHALL reset to 0, hold its value while out_done_o=1, and clear on the edge leaving DONE.
REQ-036 Without SORT_OUTPACK_CNT_EN, the out_cnt_o port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-037 Scenario: N=4, in_vld_i=4'b1010, lanes 1/3 = 5/9, out_rdy_i=1 -> out_data_o 5 then 9 on consecutive cycles; ovf_o=0.
REQ-038 Scenario: fill 14 of 16 slots with rdy=0, then a beat with in_vld_i=4'b0111 -> beat dropped, occupancy stays 14, ovf_o=1 and sticky.
REQ-039 Scenario: in_vld_i=4'b1111 with data 1,2,3,4 and in_done_vld_i in the same cycle, out_rdy_i=1 -> outputs 1,2,3,4 with out_last_o only on 4, then out_done_o for one cycle, then IDLE.
REQ-040 Scenario: in_done_vld_i with the FIFO empty -> out_done_o one cycle later; out_vld_o and out_last_o stay 0.
REQ-041 Scenario: out_rdy_i toggling 1,0,1,0 during a 20-element stream -> no loss, order preserved, pointers wrap correctly; with SORT_OUTPACK_CNT_EN, out_cnt_o=20 at out_done_o.
REQ-042 Scenario: rst pulsed low with 6 elements queued in DRAIN -> out_vld_o=0 and ovf_o=0 immediately; no out_done_o after release.
